// File: rtl/mul_pkg.sv
// Shared types and constants for the mul_sched multiplier scheduler.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RSP
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sat_pos(input int size);
        return (1 << (size - 1)) - 1;
    endfunction

    function automatic int sat_neg(input int size);
        return -(1 << (size - 1));
    endfunction

endpackage

// File: rtl/mul16.sv
// 16x16 signed multiplier: full 32-bit product plus 16-bit signed overflow flag.
module mul16 (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p,
    output logic               ovf
);
    assign p   = 32'(a) * 32'(b);
    assign ovf = !((&p[31:15]) || !(|p[31:15]));
endmodule

// File: rtl/mul8.sv
// 8x8 signed multiplier: full 16-bit product plus 8-bit signed overflow flag.
module mul8 (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p,
    output logic               ovf
);
    assign p   = 16'(a) * 16'(b);
    assign ovf = !((&p[15:7]) || !(|p[15:7]));
endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one signed multiplier among NREQ requesters.
// Optional result saturation is enabled by defining MUL_SCHED_SATURATE_EN.
module mul_sched
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SIZE = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ*SIZE-1:0]                  req_a,
    input  logic [NREQ*SIZE-1:0]                  req_b,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [mul_pkg::id_width(NREQ)-1:0]    rsp_id,
    output logic [2*SIZE-1:0]                     rsp_out,
    output logic                                  rsp_overflow
);
    localparam int IW = id_width(NREQ);

    state_e                   state_q, state_d;
    logic [IW-1:0]            last_q, last_d;
    logic [IW-1:0]            id_q, id_d;
    logic signed [SIZE-1:0]   a_q, a_d, b_q, b_d;
    logic [2*SIZE-1:0]        rsp_out_q, rsp_out_d;
    logic [IW-1:0]            rsp_id_q, rsp_id_d;
    logic                     rsp_ovf_q, rsp_ovf_d;

    logic                     grant_found;
    logic [IW-1:0]            grant_idx;
    logic [IW-1:0]            cand;
    int                       base;
    logic signed [2*SIZE-1:0] prod;
    logic                     prod_ovf;
    logic                     mul_ovf_unused;
    logic [2*SIZE-1:0]        rsp_out_next;

    generate
        if (SIZE == 8) begin : g_mul8
            mul8 u_mul (.a(a_q), .b(b_q), .p(prod), .ovf(mul_ovf_unused));
        end else begin : g_mul16
            mul16 u_mul (.a(a_q), .b(b_q), .p(prod), .ovf(mul_ovf_unused));
        end
    endgenerate

    assign prod_ovf = !((&prod[2*SIZE-1:SIZE-1]) || !(|prod[2*SIZE-1:SIZE-1]));

`ifdef MUL_SCHED_SATURATE_EN
    localparam logic [2*SIZE-1:0] SAT_POS = (2*SIZE)'(sat_pos(SIZE));
    localparam logic [2*SIZE-1:0] SAT_NEG = (2*SIZE)'(sat_neg(SIZE));

    always_comb begin
        rsp_out_next = prod;
        if (prod_ovf) begin
            rsp_out_next = prod[2*SIZE-1] ? SAT_NEG : SAT_POS;
        end
    end
`else
    assign rsp_out_next = prod;
`endif

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        rsp_out_d = rsp_out_q;
        rsp_id_d  = rsp_id_q;
        rsp_ovf_d = rsp_ovf_q;
        req_ready = '0;
        base      = int'(grant_idx) * SIZE;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d     = req_a[base +: SIZE];
                    b_d     = req_b[base +: SIZE];
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = MUL;
                end
            end
            MUL: begin
                rsp_out_d = rsp_out_next;
                rsp_ovf_d = prod_ovf;
                rsp_id_d  = id_q;
                state_d   = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= IW'(NREQ - 1);
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_out_q <= '0;
            rsp_id_q  <= '0;
            rsp_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rsp_out_q <= rsp_out_d;
            rsp_id_q  <= rsp_id_d;
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_valid    = (state_q == RSP);
    assign rsp_out      = rsp_out_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_overflow = rsp_ovf_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched (NREQ=4, SIZE=16).
// Expected values follow MUL_SCHED_SATURATE_EN when it is defined.
module tb_mul_sched;
    localparam int NREQ = 4;
    localparam int SIZE = 16;

`ifdef MUL_SCHED_SATURATE_EN
    localparam logic [31:0] EXP_POS_OVF = 32'h0000_7FFF;
    localparam logic [31:0] EXP_MIN_SQ  = 32'h0000_7FFF;
    localparam logic [31:0] EXP_NEG_OVF = 32'hFFFF_8000;
`else
    localparam logic [31:0] EXP_POS_OVF = 32'h0000_FFFE;
    localparam logic [31:0] EXP_MIN_SQ  = 32'h4000_0000;
    localparam logic [31:0] EXP_NEG_OVF = 32'hFFFF_0000;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [2*SIZE-1:0]    rsp_out;
    logic                 rsp_overflow;

    int checks = 0;
    int errors = 0;

    // Requester i holds a=i+1, b=-(i+2) during the rotation tests.
    logic [31:0] rr_prod [NREQ] = '{32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFF4, 32'hFFFF_FFEC};

    mul_sched #(.NREQ(NREQ), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_a[idx*SIZE +: SIZE] = a;
        req_b[idx*SIZE +: SIZE] = b;
    endtask

    task automatic runSingle(input int idx, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp_out, input logic exp_ovf);
        @(negedge clk);
        req_valid = '0;
        applyStimulus(idx, a, b);
        req_valid[idx] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("single_grant", 32'(req_ready), 32'(1 << idx));
        @(negedge clk);
        req_valid = '0;
        #1;
        checkOutput("single_mul_ready", 32'(req_ready), 32'd0);
        checkOutput("single_mul_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single_rsp_id", 32'(rsp_id), 32'(idx));
        checkOutput("single_rsp_out", rsp_out, exp_out);
        checkOutput("single_rsp_ovf", 32'(rsp_overflow), 32'(exp_ovf));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_out", rsp_out, 32'd0);
        checkOutput("reset_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_ovf", 32'(rsp_overflow), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runSingle(2, 16'd3, 16'hFFFB, 32'hFFFF_FFF1, 1'b0);
        runSingle(1, 16'h7FFF, 16'd2, EXP_POS_OVF, 1'b1);
        runSingle(3, 16'h8000, 16'h8000, EXP_MIN_SQ, 1'b1);
        runSingle(0, 16'h8000, 16'd1, 32'hFFFF_8000, 1'b0);
        runSingle(2, 16'h8000, 16'd2, EXP_NEG_OVF, 1'b1);

        // Fresh reset so the rotation starts from requester 0.
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 16'(i + 1), 16'(-(i + 2)));
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            if (g > 0) begin
                @(negedge clk);
                #1;
            end
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (g % NREQ)));
            @(negedge clk);
            #1;
            checkOutput("rr_mul_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
            checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rr_rsp_id", 32'(rsp_id), 32'(g % NREQ));
            checkOutput("rr_rsp_out", rsp_out, rr_prod[g % NREQ]);
            checkOutput("rr_rsp_ready", 32'(req_ready), 32'd0);
        end

        // Backpressure: requester 2 is next in rotation.
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp_grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_id", 32'(rsp_id), 32'd2);
            checkOutput("bp_out", rsp_out, rr_prod[2]);
            checkOutput("bp_ovf", 32'(rsp_overflow), 32'd0);
            checkOutput("bp_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_hs_ready", 32'(req_ready), 32'd0);
        checkOutput("bp_hs_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("bp_resume_grant", 32'(req_ready), 32'h8);
        checkOutput("bp_resume_valid", 32'(rsp_valid), 32'd0);

        // Reset while requester 3's transaction is in MUL.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mul_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_mul_out", rsp_out, 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("rst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_first_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1;
        checkOutput("rst_mul_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_out", rsp_out, rr_prod[0]);

        req_valid = '0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler that shares one signed multiplier instance among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester and latches its operands. It then registers the full-width product and an overflow flag, and returns them to the consumer tagged with the requester index. It sits between the operand producers of the arithmetic datapath and the single `mul<SIZE>` instance.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `SIZE`, 16, operand width; 8 or 16 only (matches an existing `mul<SIZE>` module)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero
- `req_a`  in  NREQ*SIZE  signed operand A; requester i at bits [i*SIZE +: SIZE]
- `req_b`  in  NREQ*SIZE  signed operand B; same packing
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  clog2(NREQ)  index of the requester that owns the result
- `rsp_out`  out  2*SIZE  signed product, or saturated product (see Configuration)
- `rsp_overflow`  out  1  product does not fit in SIZE-bit signed

## Operation
- FSM states:
  - IDLE: arbitrate. If any `req_valid` is high, assert `req_ready` for the winner only. Latch its `a`, `b` and index, then go to MUL.
  - MUL: the latched operands drive the multiplier. Register the product and overflow into the response registers, then go to RSP.
  - RSP: hold `rsp_valid`=1. When `rsp_valid & rsp_ready`, go to IDLE.
- `req_ready` is zero in MUL and RSP. There is no grant in the RSP→IDLE handshake cycle.
- Arbitration is round-robin over a pointer `last` (index of the last grant). Priority search starts at `last+1` and wraps modulo NREQ. `last` updates only on a grant.
- `req_ready` is combinational from `req_valid` and `last`. A requester must hold `a`/`b` stable while `req_valid`=1.
- Arithmetic: `rsp_out` is the full 2*SIZE-bit signed product of the SIZE-bit signed operands. The multiplier instance's own overflow output is left unconnected.
- Overflow rule (block-local): `rsp_overflow`=1 unless product bits [2*SIZE-1:SIZE-1] are all equal.
- `rsp_out`, `rsp_id` and `rsp_overflow` stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset values: state IDLE, `last`=NREQ-1 (requester 0 wins first), `rsp_valid`=0, `rsp_out`=0, `rsp_id`=0, `rsp_overflow`=0, operand registers 0.
- Latency: grant at cycle T, `rsp_valid` rises at T+2. With `rsp_ready` tied high, the next grant is possible at T+3, so peak throughput is one result per 3 cycles.
- Reset mid-operation (MUL or RSP): the transaction is dropped, no response is issued, and `last` returns to NREQ-1.
- `req_valid` deasserted after a grant has no effect; the operands are already latched.
- Simultaneous valids: exactly one grant per IDLE cycle; the others wait without losing place in the rotation.
- Continuous backpressure: the block stays in RSP indefinitely and all `req_ready` are 0.

## Configuration
- Macro `MUL_SCHED_SATURATE_EN`.
- Defined: when overflow, `rsp_out` is clamped to the SIZE-bit signed limit, sign-extended to 2*SIZE. The limit is 2^(SIZE-1)-1 if product bit 2*SIZE-1 is 0, else -2^(SIZE-1). `rsp_overflow` still reports 1.
- Undefined: `rsp_out` is the raw product and no saturation logic is built.

## Structure
- Shared package `mul_pkg`:
  - FSM state enum (IDLE, MUL, RSP)
  - `clog2`-based id-width helper
  - saturation-limit constants as functions of SIZE
- One sub-module: the existing `mul8` / `mul16` multiplier, selected by SIZE through a generate block. Round-robin arbitration stays inline.

## Test plan
(SIZE=16, NREQ=4)
- Only requester 2 valid with a=3, b=-5 → `req_ready`=0100 at T. At T+2: `rsp_valid`=1, `rsp_id`=2, `rsp_out`=0xFFFFFFF1, `rsp_overflow`=0.
- a=0x7FFF, b=2 → `rsp_overflow`=1. `rsp_out`=0x0000FFFE without the macro, 0x00007FFF with `MUL_SCHED_SATURATE_EN`.
- a=-32768, b=-32768 → `rsp_overflow`=1, `rsp_out`=0x40000000 (raw) or 0x00007FFF (saturated). a=-32768, b=1 → 0xFFFF8000, `rsp_overflow`=0.
- All four requesters held valid, `rsp_ready`=1 → grant order 0,1,2,3,0,1; one grant every 3 cycles.
- `rsp_ready` held 0 for 5 cycles in RSP → `rsp_*` outputs stable and `req_ready`=0000 throughout. The grant resumes the cycle after the handshake completes.
- `rst` asserted during MUL → `rsp_valid` never rises for that transaction. After release, with all requesters valid, the first grant is requester 0.
